// File: rtl/instr_buf_ring_if.sv
// instr_buf_ring_if
//   Bus between the host/control side and the instruction buffer ring.
//   master modport: loader + control unit (drives requests, receives status/data).
//   slave  modport: instr_buf_ring.
//   Load group : ld_we, ld_addr, ld_data, ld_commit, ld_len  -> ld_rdy, ld_buf_idx, ld_err
//   Exec group : ex_re, ex_addr, ex_release                  -> ex_buf_vld, ex_buf_idx,
//                                                               ex_len, ex_data, ex_vld,
//                                                               ex_last, ex_err
//   Status     : n_ready
//   INSTR_BUF_PARITY_EN adds ex_parity_err and the tst_par_flip hook.
interface instr_buf_ring_if #(
  parameter int INSTR_L = 32,
  parameter int ADDR_L  = 8,
  parameter int N_BUF   = 4
);
  localparam int PW = $clog2(N_BUF);

  logic               ld_we;
  logic [ADDR_L-1:0]  ld_addr;
  logic [INSTR_L-1:0] ld_data;
  logic               ld_commit;
  logic [ADDR_L:0]    ld_len;
  logic               ld_rdy;
  logic [PW-1:0]      ld_buf_idx;
  logic               ld_err;

  logic               ex_re;
  logic [ADDR_L-1:0]  ex_addr;
  logic               ex_release;
  logic               ex_buf_vld;
  logic [PW-1:0]      ex_buf_idx;
  logic [ADDR_L:0]    ex_len;
  logic [INSTR_L-1:0] ex_data;
  logic               ex_vld;
  logic               ex_last;
  logic               ex_err;

  logic [PW:0]        n_ready;

`ifdef INSTR_BUF_PARITY_EN
  logic               tst_par_flip;
  logic               ex_parity_err;
`endif

  modport master (
`ifdef INSTR_BUF_PARITY_EN
    output tst_par_flip,
    input  ex_parity_err,
`endif
    output ld_we, ld_addr, ld_data, ld_commit, ld_len,
    output ex_re, ex_addr, ex_release,
    input  ld_rdy, ld_buf_idx, ld_err,
    input  ex_buf_vld, ex_buf_idx, ex_len, ex_data, ex_vld, ex_last, ex_err,
    input  n_ready
  );

  modport slave (
`ifdef INSTR_BUF_PARITY_EN
    input  tst_par_flip,
    output ex_parity_err,
`endif
    input  ld_we, ld_addr, ld_data, ld_commit, ld_len,
    input  ex_re, ex_addr, ex_release,
    output ld_rdy, ld_buf_idx, ld_err,
    output ex_buf_vld, ex_buf_idx, ex_len, ex_data, ex_vld, ex_last, ex_err,
    output n_ready
  );
endinterface

// File: rtl/instr_buf_ring.sv
// instr_buf_ring
//   Ring of N_BUF instruction buffers. The host fills the buffer at wr_ptr and
//   commits it with a length; the control unit reads from the buffer at rd_ptr
//   and releases it when done. Reads are pipelined with RD_LATENCY cycles.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-high
//   bus  - instr_buf_ring_if.slave (load, exec and status groups)
// Optional feature macro: INSTR_BUF_PARITY_EN
//   Stores an even-parity bit per word and flags mismatches on ex_parity_err.
//
// Per-buffer state
//   state     | meaning
//   BUF_FREE  | owned by the loader, may be written and committed
//   BUF_READY | committed with a length, owned by the exec side until released
module instr_buf_ring #(
  parameter int INSTR_L    = 32,
  parameter int ADDR_L     = 8,
  parameter int N_BUF      = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  instr_buf_ring_if.slave bus
);
  localparam int PW    = $clog2(N_BUF);
  localparam int DEPTH = 1 << ADDR_L;
  localparam int AW    = PW + ADDR_L;
`ifdef INSTR_BUF_PARITY_EN
  localparam int MEM_W = INSTR_L + 1;
`else
  localparam int MEM_W = INSTR_L;
`endif
  localparam logic [ADDR_L:0] LEN_MAX = (ADDR_L+1)'(DEPTH);
  localparam logic [ADDR_L:0] LEN_ONE = (ADDR_L+1)'(1);
  localparam logic [PW:0]     CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);

  typedef enum logic {BUF_FREE = 1'b0, BUF_READY = 1'b1} buf_state_e;

  buf_state_e         r_state [N_BUF];
  logic [ADDR_L:0]    r_len   [N_BUF];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW:0]        r_n_ready;
  logic               r_ld_err;
  logic               r_ex_err;

  logic [MEM_W-1:0]   r_mem [N_BUF*DEPTH];

  // read pipeline, stage RD_LATENCY-1 drives the outputs
  logic               r_pv [RD_LATENCY];
  logic               r_pl [RD_LATENCY];
  logic [INSTR_L-1:0] r_pd [RD_LATENCY];
`ifdef INSTR_BUF_PARITY_EN
  logic               r_pp [RD_LATENCY];
`endif

  logic               w_ld_rdy;
  logic               w_ex_buf_vld;
  logic [ADDR_L:0]    w_ex_len;
  logic               w_len_ok;
  logic               w_wr_ok;
  logic               w_commit_ok;
  logic               w_addr_ok;
  logic               w_rd_ok;
  logic               w_rel_ok;
  logic               w_rd_last;
  logic               w_ld_err_nx;
  logic               w_ex_err_nx;
  logic [AW-1:0]      w_wr_addr;
  logic [AW-1:0]      w_rd_addr;
  logic [MEM_W-1:0]   w_rd_word;
  logic [MEM_W-1:0]   w_wr_word;

  // Ownership is tracked per buffer; a FREE slot at wr_ptr is equivalent to
  // n_ready < N_BUF and a READY slot at rd_ptr to n_ready > 0.
  assign w_ld_rdy     = (r_state[r_wr_ptr] == BUF_FREE);
  assign w_ex_buf_vld = (r_state[r_rd_ptr] == BUF_READY);
  assign w_ex_len     = w_ex_buf_vld ? r_len[r_rd_ptr] : '0;

  assign w_len_ok    = (bus.ld_len != '0) && (bus.ld_len <= LEN_MAX);
  assign w_wr_ok     = bus.ld_we && w_ld_rdy;
  assign w_commit_ok = bus.ld_commit && w_ld_rdy && w_len_ok;
  assign w_addr_ok   = ({1'b0, bus.ex_addr} < w_ex_len);
  assign w_rd_ok     = bus.ex_re && w_ex_buf_vld && w_addr_ok;
  assign w_rel_ok    = bus.ex_release && w_ex_buf_vld;
  assign w_rd_last   = ({1'b0, bus.ex_addr} == (w_ex_len - LEN_ONE));

  assign w_ld_err_nx = (bus.ld_we && !w_ld_rdy) ||
                       (bus.ld_commit && !(w_ld_rdy && w_len_ok));
  assign w_ex_err_nx = (bus.ex_re && !(w_ex_buf_vld && w_addr_ok)) ||
                       (bus.ex_release && !w_ex_buf_vld);

  assign w_wr_addr = {r_wr_ptr, bus.ld_addr};
  assign w_rd_addr = {r_rd_ptr, bus.ex_addr};
  assign w_rd_word = r_mem[w_rd_addr];

`ifdef INSTR_BUF_PARITY_EN
  // tst_par_flip deliberately stores the wrong parity bit
  assign w_wr_word = {(^bus.ld_data) ^ bus.tst_par_flip, bus.ld_data};
`else
  assign w_wr_word = bus.ld_data;
`endif

  // Data captured at issue, so a release in the same or a later cycle cannot
  // disturb reads already in flight.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !rst) begin
      r_mem[w_wr_addr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BUF; i++) begin
        r_state[i] <= BUF_FREE;
        r_len[i]   <= '0;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_n_ready <= '0;
      r_ld_err  <= 1'b0;
      r_ex_err  <= 1'b0;
    end else begin
      r_ld_err <= w_ld_err_nx;
      r_ex_err <= w_ex_err_nx;
      // commit needs a FREE slot and release a READY one, so they never hit
      // the same buffer in one cycle
      if (w_commit_ok) begin
        r_state[r_wr_ptr] <= BUF_READY;
        r_len[r_wr_ptr]   <= bus.ld_len;
        r_wr_ptr          <= r_wr_ptr + PTR_ONE;
      end
      if (w_rel_ok) begin
        r_state[r_rd_ptr] <= BUF_FREE;
        r_rd_ptr          <= r_rd_ptr + PTR_ONE;
      end
      case ({w_commit_ok, w_rel_ok})
        2'b10:   r_n_ready <= r_n_ready + CNT_ONE;
        2'b01:   r_n_ready <= r_n_ready - CNT_ONE;
        default: r_n_ready <= r_n_ready;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pl[i] <= 1'b0;
        r_pd[i] <= '0;
`ifdef INSTR_BUF_PARITY_EN
        r_pp[i] <= 1'b0;
`endif
      end
    end else begin
      r_pv[0] <= w_rd_ok;
      r_pl[0] <= w_rd_ok && w_rd_last;
      if (w_rd_ok) begin
        r_pd[0] <= w_rd_word[INSTR_L-1:0];
      end
`ifdef INSTR_BUF_PARITY_EN
      r_pp[0] <= w_rd_ok && ((^w_rd_word[INSTR_L-1:0]) != w_rd_word[INSTR_L]);
`endif
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
        r_pd[i] <= r_pd[i-1];
`ifdef INSTR_BUF_PARITY_EN
        r_pp[i] <= r_pp[i-1];
`endif
      end
    end
  end

  assign bus.ld_rdy     = w_ld_rdy;
  assign bus.ld_buf_idx = r_wr_ptr;
  assign bus.ld_err     = r_ld_err;
  assign bus.ex_buf_vld = w_ex_buf_vld;
  assign bus.ex_buf_idx = r_rd_ptr;
  assign bus.ex_len     = w_ex_len;
  assign bus.ex_data    = r_pd[RD_LATENCY-1];
  assign bus.ex_vld     = r_pv[RD_LATENCY-1];
  assign bus.ex_last    = r_pl[RD_LATENCY-1];
  assign bus.ex_err     = r_ex_err;
  assign bus.n_ready    = r_n_ready;
`ifdef INSTR_BUF_PARITY_EN
  assign bus.ex_parity_err = r_pp[RD_LATENCY-1];
`endif

endmodule

// File: tb/tb_instr_buf_ring.sv
// tb_instr_buf_ring
//   Directed bench for instr_buf_ring (INSTR_L=32, ADDR_L=8, N_BUF=4, RD_LATENCY=1).
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   at the same point after the following edge.
module tb_instr_buf_ring;
  localparam int INSTR_L    = 32;
  localparam int ADDR_L     = 8;
  localparam int N_BUF      = 4;
  localparam int RD_LATENCY = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instr_buf_ring_if #(.INSTR_L(INSTR_L), .ADDR_L(ADDR_L), .N_BUF(N_BUF)) bus ();

  instr_buf_ring #(
    .INSTR_L(INSTR_L), .ADDR_L(ADDR_L), .N_BUF(N_BUF), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.ld_we      = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.ld_commit  = 1'b0;
    bus.ld_len     = '0;
    bus.ex_re      = 1'b0;
    bus.ex_addr    = '0;
    bus.ex_release = 1'b0;
`ifdef INSTR_BUF_PARITY_EN
    bus.tst_par_flip = 1'b0;
`endif
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // writes n words base+0..base+n-1 into the load buffer, then commits len n
  task automatic load_buf(input int n, input logic [31:0] base);
    for (int a = 0; a < n; a++) begin
      bus.ld_we   = 1'b1;
      bus.ld_addr = ADDR_L'(a);
      bus.ld_data = base + 32'(a);
      tick();
    end
    bus.ld_we     = 1'b0;
    bus.ld_commit = 1'b1;
    bus.ld_len    = (ADDR_L+1)'(n);
    tick();
    bus.ld_commit = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (bus.n_ready !== 3'd0) begin failures++; $display("FAIL reset_n_ready got=%0d exp=0", bus.n_ready); end
    checks++; if (bus.ld_rdy !== 1'b1) begin failures++; $display("FAIL reset_ld_rdy got=%b exp=1", bus.ld_rdy); end
    checks++; if (bus.ex_buf_vld !== 1'b0) begin failures++; $display("FAIL reset_ex_buf_vld got=%b exp=0", bus.ex_buf_vld); end
    checks++; if (bus.ex_len !== 9'd0) begin failures++; $display("FAIL reset_ex_len got=%0d exp=0", bus.ex_len); end
    checks++; if (bus.ld_buf_idx !== 2'd0 || bus.ex_buf_idx !== 2'd0) begin failures++; $display("FAIL reset_ptrs got=%0d/%0d exp=0/0", bus.ld_buf_idx, bus.ex_buf_idx); end
    checks++; if (bus.ex_vld !== 1'b0 || bus.ex_last !== 1'b0 || bus.ex_data !== 32'd0) begin failures++; $display("FAIL reset_ex_out got=%b/%b/%h exp=0/0/0", bus.ex_vld, bus.ex_last, bus.ex_data); end
    checks++; if (bus.ld_err !== 1'b0 || bus.ex_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b/%b exp=0/0", bus.ld_err, bus.ex_err); end
  endtask

  task automatic test_load_read();
    do_reset();
    load_buf(4, 32'hA0);
    checks++; if (bus.n_ready !== 3'd1) begin failures++; $display("FAIL lr_n_ready got=%0d exp=1", bus.n_ready); end
    checks++; if (bus.ld_buf_idx !== 2'd1) begin failures++; $display("FAIL lr_ld_buf_idx got=%0d exp=1", bus.ld_buf_idx); end
    checks++; if (bus.ex_buf_vld !== 1'b1 || bus.ex_len !== 9'd4) begin failures++; $display("FAIL lr_ex_buf got=%b/%0d exp=1/4", bus.ex_buf_vld, bus.ex_len); end
    for (int a = 0; a < 4; a++) begin
      bus.ex_re   = 1'b1;
      bus.ex_addr = ADDR_L'(a);
      tick();
      checks++; if (bus.ex_vld !== 1'b1 || bus.ex_data !== 32'hA0 + 32'(a)) begin failures++; $display("FAIL lr_read a=%0d got=%b/%h exp=1/%h", a, bus.ex_vld, bus.ex_data, 32'hA0 + 32'(a)); end
      checks++; if (bus.ex_last !== (a == 3)) begin failures++; $display("FAIL lr_last a=%0d got=%b exp=%b", a, bus.ex_last, (a == 3)); end
    end
    bus.ex_re = 1'b0;
    tick();
    checks++; if (bus.ex_vld !== 1'b0) begin failures++; $display("FAIL lr_idle_vld got=%b exp=0", bus.ex_vld); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int b = 0; b < 4; b++) load_buf(b + 2, 32'h1000 * 32'(b + 1));
    checks++; if (bus.ld_rdy !== 1'b0 || bus.n_ready !== 3'd4) begin failures++; $display("FAIL fill_full got=%b/%0d exp=0/4", bus.ld_rdy, bus.n_ready); end
    checks++; if (bus.ld_buf_idx !== 2'd0 || bus.ex_buf_idx !== 2'd0) begin failures++; $display("FAIL fill_ptrs got=%0d/%0d exp=0/0", bus.ld_buf_idx, bus.ex_buf_idx); end
    bus.ld_we   = 1'b1;
    bus.ld_addr = '0;
    bus.ld_data = 32'hDEAD_BEEF;
    tick();
    bus.ld_we = 1'b0;
    checks++; if (bus.ld_err !== 1'b1) begin failures++; $display("FAIL fill_ld_err got=%b exp=1", bus.ld_err); end
    bus.ex_re   = 1'b1;
    bus.ex_addr = '0;
    tick();
    bus.ex_re = 1'b0;
    checks++; if (bus.ld_err !== 1'b0) begin failures++; $display("FAIL fill_ld_err_pulse got=%b exp=0", bus.ld_err); end
    checks++; if (bus.ex_vld !== 1'b1 || bus.ex_data !== 32'h1000) begin failures++; $display("FAIL fill_no_write got=%b/%h exp=1/00001000", bus.ex_vld, bus.ex_data); end
    bus.ex_release = 1'b1;
    tick();
    bus.ex_release = 1'b0;
    checks++; if (bus.ld_rdy !== 1'b1 || bus.ld_buf_idx !== 2'd0) begin failures++; $display("FAIL fill_release_ld got=%b/%0d exp=1/0", bus.ld_rdy, bus.ld_buf_idx); end
    checks++; if (bus.n_ready !== 3'd3 || bus.ex_buf_idx !== 2'd1 || bus.ex_len !== 9'd3) begin failures++; $display("FAIL fill_release_ex got=%0d/%0d/%0d exp=3/1/3", bus.n_ready, bus.ex_buf_idx, bus.ex_len); end
    bus.ex_re   = 1'b1;
    bus.ex_addr = 8'd2;
    tick();
    bus.ex_re = 1'b0;
    checks++; if (bus.ex_data !== 32'h2002 || bus.ex_last !== 1'b1) begin failures++; $display("FAIL fill_buf1_read got=%h/%b exp=00002002/1", bus.ex_data, bus.ex_last); end
  endtask

  task automatic test_commit_release();
    do_reset();
    load_buf(2, 32'h100);
    load_buf(3, 32'h200);
    load_buf(4, 32'h300);
    bus.ex_release = 1'b1;
    tick();
    bus.ex_release = 1'b0;
    checks++; if (bus.n_ready !== 3'd2 || bus.ld_buf_idx !== 2'd3 || bus.ex_buf_idx !== 2'd1) begin failures++; $display("FAIL cr_setup got=%0d/%0d/%0d exp=2/3/1", bus.n_ready, bus.ld_buf_idx, bus.ex_buf_idx); end
    bus.ld_we   = 1'b1;
    bus.ld_addr = '0;
    bus.ld_data = 32'h400;
    tick();
    bus.ld_we      = 1'b0;
    bus.ld_commit  = 1'b1;
    bus.ld_len     = 9'd1;
    bus.ex_release = 1'b1;
    tick();
    bus.ld_commit  = 1'b0;
    bus.ex_release = 1'b0;
    checks++; if (bus.n_ready !== 3'd2) begin failures++; $display("FAIL cr_n_ready got=%0d exp=2", bus.n_ready); end
    checks++; if (bus.ld_buf_idx !== 2'd0 || bus.ex_buf_idx !== 2'd2) begin failures++; $display("FAIL cr_ptrs got=%0d/%0d exp=0/2", bus.ld_buf_idx, bus.ex_buf_idx); end
    checks++; if (bus.ex_len !== 9'd4 || bus.ld_rdy !== 1'b1) begin failures++; $display("FAIL cr_len got=%0d/%b exp=4/1", bus.ex_len, bus.ld_rdy); end
    bus.ex_re   = 1'b1;
    bus.ex_addr = 8'd3;
    tick();
    bus.ex_re = 1'b0;
    checks++; if (bus.ex_data !== 32'h303 || bus.ex_last !== 1'b1) begin failures++; $display("FAIL cr_read got=%h/%b exp=00000303/1", bus.ex_data, bus.ex_last); end
  endtask

  task automatic test_errors();
    do_reset();
    bus.ex_re = 1'b1;
    tick();
    bus.ex_re = 1'b0;
    checks++; if (bus.ex_err !== 1'b1 || bus.ex_vld !== 1'b0) begin failures++; $display("FAIL err_re_empty got=%b/%b exp=1/0", bus.ex_err, bus.ex_vld); end
    tick();
    checks++; if (bus.ex_err !== 1'b0) begin failures++; $display("FAIL err_ex_pulse got=%b exp=0", bus.ex_err); end
    bus.ex_release = 1'b1;
    tick();
    bus.ex_release = 1'b0;
    checks++; if (bus.ex_err !== 1'b1 || bus.ex_buf_idx !== 2'd0 || bus.n_ready !== 3'd0) begin failures++; $display("FAIL err_rel_empty got=%b/%0d/%0d exp=1/0/0", bus.ex_err, bus.ex_buf_idx, bus.n_ready); end
    bus.ld_commit = 1'b1;
    bus.ld_len    = 9'd0;
    tick();
    checks++; if (bus.ld_err !== 1'b1 || bus.n_ready !== 3'd0) begin failures++; $display("FAIL err_len0 got=%b/%0d exp=1/0", bus.ld_err, bus.n_ready); end
    bus.ld_len = 9'd257;
    tick();
    bus.ld_commit = 1'b0;
    checks++; if (bus.ld_err !== 1'b1 || bus.n_ready !== 3'd0 || bus.ld_buf_idx !== 2'd0) begin failures++; $display("FAIL err_len257 got=%b/%0d/%0d exp=1/0/0", bus.ld_err, bus.n_ready, bus.ld_buf_idx); end
    load_buf(4, 32'h50);
    bus.ex_re   = 1'b1;
    bus.ex_addr = 8'd4;
    tick();
    checks++; if (bus.ex_err !== 1'b1 || bus.ex_vld !== 1'b0) begin failures++; $display("FAIL err_addr_oob got=%b/%b exp=1/0", bus.ex_err, bus.ex_vld); end
    bus.ex_addr = 8'd3;
    tick();
    bus.ex_re = 1'b0;
    checks++; if (bus.ex_err !== 1'b0 || bus.ex_vld !== 1'b1 || bus.ex_data !== 32'h53 || bus.ex_last !== 1'b1) begin failures++; $display("FAIL err_addr_max got=%b/%b/%h/%b exp=0/1/00000053/1", bus.ex_err, bus.ex_vld, bus.ex_data, bus.ex_last); end
    bus.ld_commit = 1'b1;
    bus.ld_len    = 9'd256;
    tick();
    bus.ld_commit = 1'b0;
    checks++; if (bus.ld_err !== 1'b0 || bus.n_ready !== 3'd2 || bus.ex_len !== 9'd4) begin failures++; $display("FAIL err_len256 got=%b/%0d/%0d exp=0/2/4", bus.ld_err, bus.n_ready, bus.ex_len); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_buf(4, 32'hF0);
    load_buf(2, 32'h70);
    bus.ex_re   = 1'b1;
    bus.ex_addr = 8'd2;
    tick();
    checks++; if (bus.ex_vld !== 1'b1 || bus.ex_data !== 32'hF2 || bus.ex_last !== 1'b0) begin failures++; $display("FAIL b2b_a2 got=%b/%h/%b exp=1/000000f2/0", bus.ex_vld, bus.ex_data, bus.ex_last); end
    bus.ex_addr    = 8'd3;
    bus.ex_release = 1'b1;
    tick();
    bus.ex_release = 1'b0;
    checks++; if (bus.ex_vld !== 1'b1 || bus.ex_data !== 32'hF3 || bus.ex_last !== 1'b1) begin failures++; $display("FAIL b2b_a3 got=%b/%h/%b exp=1/000000f3/1", bus.ex_vld, bus.ex_data, bus.ex_last); end
    checks++; if (bus.ex_buf_idx !== 2'd1 || bus.n_ready !== 3'd1 || bus.ex_len !== 9'd2) begin failures++; $display("FAIL b2b_idx got=%0d/%0d/%0d exp=1/1/2", bus.ex_buf_idx, bus.n_ready, bus.ex_len); end
    bus.ex_addr = 8'd0;
    tick();
    checks++; if (bus.ex_vld !== 1'b1 || bus.ex_data !== 32'h70 || bus.ex_last !== 1'b0) begin failures++; $display("FAIL b2b_new0 got=%b/%h/%b exp=1/00000070/0", bus.ex_vld, bus.ex_data, bus.ex_last); end
    bus.ex_addr = 8'd1;
    tick();
    bus.ex_re = 1'b0;
    checks++; if (bus.ex_data !== 32'h71 || bus.ex_last !== 1'b1) begin failures++; $display("FAIL b2b_new1 got=%h/%b exp=00000071/1", bus.ex_data, bus.ex_last); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    load_buf(2, 32'h60);
    bus.ex_re   = 1'b1;
    bus.ex_addr = 8'd0;
    tick();
    bus.ex_addr = 8'd1;
    rst         = 1'b1;
    tick();
    checks++; if (bus.ex_vld !== 1'b0) begin failures++; $display("FAIL rif_vld_in_rst got=%b exp=0", bus.ex_vld); end
    rst       = 1'b0;
    bus.ex_re = 1'b0;
    tick();
    checks++; if (bus.ex_vld !== 1'b0 || bus.ex_err !== 1'b0) begin failures++; $display("FAIL rif_vld_after got=%b/%b exp=0/0", bus.ex_vld, bus.ex_err); end
    checks++; if (bus.n_ready !== 3'd0 || bus.ld_rdy !== 1'b1 || bus.ex_buf_vld !== 1'b0) begin failures++; $display("FAIL rif_state got=%0d/%b/%b exp=0/1/0", bus.n_ready, bus.ld_rdy, bus.ex_buf_vld); end
  endtask

`ifdef INSTR_BUF_PARITY_EN
  task automatic test_parity();
    do_reset();
    bus.ld_we        = 1'b1;
    bus.ld_addr      = 8'd0;
    bus.ld_data      = 32'h5;
    bus.tst_par_flip = 1'b1;
    tick();
    bus.tst_par_flip = 1'b0;
    bus.ld_addr      = 8'd1;
    bus.ld_data      = 32'h7;
    tick();
    bus.ld_we     = 1'b0;
    bus.ld_commit = 1'b1;
    bus.ld_len    = 9'd2;
    tick();
    bus.ld_commit = 1'b0;
    bus.ex_re     = 1'b1;
    bus.ex_addr   = 8'd0;
    tick();
    checks++; if (bus.ex_vld !== 1'b1 || bus.ex_parity_err !== 1'b1) begin failures++; $display("FAIL par_flip got=%b/%b exp=1/1", bus.ex_vld, bus.ex_parity_err); end
    bus.ex_addr = 8'd1;
    tick();
    bus.ex_re = 1'b0;
    checks++; if (bus.ex_vld !== 1'b1 || bus.ex_parity_err !== 1'b0) begin failures++; $display("FAIL par_clean got=%b/%b exp=1/0", bus.ex_vld, bus.ex_parity_err); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    test_reset();
    test_load_read();
    test_fill();
    test_commit_release();
    test_errors();
    test_back_to_back();
    test_reset_inflight();
`ifdef INSTR_BUF_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
